// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: operation codes, instruction field encodings and
// the execute-stage control payload. Used by the decode stage and the ALU.
package alu_defs_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned IMM_W   = 16;

  // ALU operation codes; 2 and D-F are reserved and never produced.
  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_NOR = 4'h6,
    ALU_ULT = 4'h7,
    ALU_SLT = 4'h8,
    ALU_SLL = 4'h9,
    ALU_SRL = 4'hA,
    ALU_SRA = 4'hB,
    ALU_GTZ = 4'hC
  } alu_op_e;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_BGTZ  = 6'h07;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction bits [5:0])
  localparam logic [FUNCT_W-1:0] F_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] F_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] F_SLLV = 6'h04;
  localparam logic [FUNCT_W-1:0] F_SRLV = 6'h06;
  localparam logic [FUNCT_W-1:0] F_SRAV = 6'h07;
  localparam logic [FUNCT_W-1:0] F_JR   = 6'h08;
  localparam logic [FUNCT_W-1:0] F_JALR = 6'h09;
  localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] F_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] F_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] F_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] F_SLTU = 6'h2B;

  // Execute-stage ALU control payload
  typedef struct packed {
    logic            valid;
    alu_op_e         aluop;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            illegal;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_CTRL_BUBBLE = '{
    valid:   1'b0,
    aluop:   ALU_ADD,
    in1:     '0,
    in2:     '0,
    illegal: 1'b0
  };

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU decode: maps instruction fields and register operands to
// an ALU operation and its two operands, flagging unsupported encodings.
//   OpCode/Funct/Shamt/Imm16 : instruction fields
//   RsData/RtData            : register-file read values
//   ALUOp/In1/In2            : ALU operation and operands
//   illegal                  : encoding not supported (outputs forced to Add 0,0)
module alu_op_decode
  import alu_defs_pkg::*;
(
  input  logic [OPC_W-1:0]   OpCode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [XLEN-1:0]    RsData,
  input  logic [XLEN-1:0]    RtData,
  input  logic [IMM_W-1:0]   Imm16,
  output alu_op_e            ALUOp,
  output logic [XLEN-1:0]    In1,
  output logic [XLEN-1:0]    In2,
  output logic               illegal
);

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;

  assign imm_sext = {{(XLEN-IMM_W){Imm16[IMM_W-1]}}, Imm16};
  assign imm_zext = XLEN'(Imm16);

  // Opcode/funct decode; illegal encodings collapse to Add with zero operands
  always_comb begin
    ALUOp   = ALU_ADD;
    In1     = '0;
    In2     = '0;
    illegal = 1'b0;
    case (OpCode)
      OP_RTYPE: begin
        In1 = RsData;
        In2 = RtData;
        case (Funct)
          F_ADD, F_ADDU, F_JR, F_JALR: ALUOp = ALU_ADD;
          F_SUB, F_SUBU:               ALUOp = ALU_SUB;
          F_AND:                       ALUOp = ALU_AND;
          F_OR:                        ALUOp = ALU_OR;
          F_XOR:                       ALUOp = ALU_XOR;
          F_NOR:                       ALUOp = ALU_NOR;
          F_SLT:                       ALUOp = ALU_SLT;
          F_SLTU:                      ALUOp = ALU_ULT;
          F_SLL: begin ALUOp = ALU_SLL; In1 = XLEN'(Shamt); end
          F_SRL: begin ALUOp = ALU_SRL; In1 = XLEN'(Shamt); end
          F_SRA: begin ALUOp = ALU_SRA; In1 = XLEN'(Shamt); end
          // variable shifts take the amount from the low bits of rs
          F_SLLV: begin ALUOp = ALU_SLL; In1 = XLEN'(RsData[SHAMT_W-1:0]); end
          F_SRLV: begin ALUOp = ALU_SRL; In1 = XLEN'(RsData[SHAMT_W-1:0]); end
          F_SRAV: begin ALUOp = ALU_SRA; In1 = XLEN'(RsData[SHAMT_W-1:0]); end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin ALUOp = ALU_ADD; In1 = RsData; In2 = imm_sext; end
      OP_SLTI:  begin ALUOp = ALU_SLT; In1 = RsData; In2 = imm_sext; end
      OP_SLTIU: begin ALUOp = ALU_ULT; In1 = RsData; In2 = imm_sext; end
      OP_ANDI:  begin ALUOp = ALU_AND; In1 = RsData; In2 = imm_zext; end
      OP_ORI:   begin ALUOp = ALU_OR;  In1 = RsData; In2 = imm_zext; end
      OP_XORI:  begin ALUOp = ALU_XOR; In1 = RsData; In2 = imm_zext; end
      // lui is a left shift of the immediate by 16
      OP_LUI:   begin ALUOp = ALU_SLL; In1 = XLEN'(IMM_W); In2 = imm_zext; end
      OP_BEQ, OP_BNE: begin ALUOp = ALU_SUB; In1 = RsData; In2 = RtData; end
      OP_BGTZ:  begin ALUOp = ALU_GTZ; In1 = RsData; In2 = '0; end
      default:  illegal = 1'b1;
    endcase
    if (illegal) begin
      ALUOp = ALU_ADD;
      In1   = '0;
      In2   = '0;
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Decode-to-execute pipeline register for ALU controls. Decodes the current
// instruction and registers the result with one cycle of latency.
//   clk, reset (async, active-low)
//   valid_in, OpCode, Funct, Shamt, RsData, RtData, Imm16 : decode-stage inputs
//   stall : hold registered outputs; flush : insert bubble (wins over stall)
//   valid_out, ALUOp, In1, In2, illegal : registered execute-stage controls
module alu_ctrl_stage
  import alu_defs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [OPC_W-1:0]     OpCode,
  input  logic [FUNCT_W-1:0]   Funct,
  input  logic [SHAMT_W-1:0]   Shamt,
  input  logic [XLEN-1:0]      RsData,
  input  logic [XLEN-1:0]      RtData,
  input  logic [IMM_W-1:0]     Imm16,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 valid_out,
  output logic [ALUOP_W-1:0]   ALUOp,
  output logic [XLEN-1:0]      In1,
  output logic [XLEN-1:0]      In2,
  output logic                 illegal
);

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_in1;
  logic [XLEN-1:0] dec_in2;
  logic            dec_illegal;
  alu_ctrl_t       ctrl_q;
  alu_ctrl_t       ctrl_d;

  alu_op_decode u_decode (
    .OpCode  (OpCode),
    .Funct   (Funct),
    .Shamt   (Shamt),
    .RsData  (RsData),
    .RtData  (RtData),
    .Imm16   (Imm16),
    .ALUOp   (dec_op),
    .In1     (dec_in1),
    .In2     (dec_in2),
    .illegal (dec_illegal)
  );

  // Next-state select: flush > stall > new instruction > bubble
  always_comb begin
    ctrl_d = ctrl_q;
    if (flush) begin
      ctrl_d = ALU_CTRL_BUBBLE;
    end else if (stall) begin
      ctrl_d = ctrl_q;
    end else if (valid_in) begin
      ctrl_d = '{valid: 1'b1, aluop: dec_op, in1: dec_in1, in2: dec_in2,
                 illegal: dec_illegal};
    end else begin
      ctrl_d = ALU_CTRL_BUBBLE;
    end
  end

  // Stage register; reset discards any held (stalled) instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= ALU_CTRL_BUBBLE;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign valid_out = ctrl_q.valid;
  assign ALUOp     = ctrl_q.aluop;
  assign In1       = ctrl_q.in1;
  assign In2       = ctrl_q.in2;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: directed cases plus random stimulus
// checked against a behavioural instruction-level model.
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [15:0] Imm16;
  logic        stall;
  logic        flush;
  logic        valid_out;
  logic [3:0]  ALUOp;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        illegal;

  alu_ctrl_stage dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .OpCode    (OpCode),
    .Funct     (Funct),
    .Shamt     (Shamt),
    .RsData    (RsData),
    .RtData    (RtData),
    .Imm16     (Imm16),
    .stall     (stall),
    .flush     (flush),
    .valid_out (valid_out),
    .ALUOp     (ALUOp),
    .In1       (In1),
    .In2       (In2),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  exp_t expq[$];
  exp_t mstate;
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  logic [5:0] legal_ops [14] = '{6'h00, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09, 6'h0A,
                                 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] legal_fn  [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
                                 6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h2A, 6'h2B};

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    cmp({tag, ".valid_out"}, 32'(valid_out), 32'(e.v));
    cmp({tag, ".ALUOp"},     32'(ALUOp),     32'(e.op));
    cmp({tag, ".In1"},       In1,            e.a);
    cmp({tag, ".In2"},       In2,            e.b);
    cmp({tag, ".illegal"},   32'(illegal),   32'(e.ill));
  endtask

  task automatic lit(input string tag, input logic v, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic ill);
    exp_t e;
    e = '{v: v, op: op, a: a, b: b, ill: ill};
    check_outs(tag, e);
  endtask

  // Instruction-level reference: what the ALU should be told to do
  function automatic exp_t ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] sh, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [15:0] imm);
    exp_t        r;
    logic [31:0] sx;
    logic [31:0] zx;
    logic        ok;
    sx = 32'($signed(imm));
    zx = 32'(imm);
    ok = 1'b1;
    r  = '{v: 1'b1, op: 4'h0, a: rs, b: rt, ill: 1'b0};
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21, 6'h08, 6'h09: r.op = 4'h0;
        6'h22, 6'h23: r.op = 4'h1;
        6'h24: r.op = 4'h3;
        6'h25: r.op = 4'h4;
        6'h26: r.op = 4'h5;
        6'h27: r.op = 4'h6;
        6'h2A: r.op = 4'h8;
        6'h2B: r.op = 4'h7;
        6'h00, 6'h04: r.op = 4'h9;
        6'h02, 6'h06: r.op = 4'hA;
        6'h03, 6'h07: r.op = 4'hB;
        default: ok = 1'b0;
      endcase
      if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) r.a = 32'(sh);
      if (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) r.a = rs % 32;
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: begin r.op = 4'h0; r.b = sx; end
        6'h0A: begin r.op = 4'h8; r.b = sx; end
        6'h0B: begin r.op = 4'h7; r.b = sx; end
        6'h0C: begin r.op = 4'h3; r.b = zx; end
        6'h0D: begin r.op = 4'h4; r.b = zx; end
        6'h0E: begin r.op = 4'h5; r.b = zx; end
        6'h0F: begin r.op = 4'h9; r.a = 32'd16; r.b = zx; end
        6'h04, 6'h05: r.op = 4'h1;
        6'h07: begin r.op = 4'hC; r.b = 32'd0; end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) r = '{v: 1'b1, op: 4'h0, a: 32'd0, b: 32'd0, ill: 1'b1};
    return r;
  endfunction

  // Apply one cycle of inputs, advance the model, queue the post-edge expectation
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm, input logic st, input logic fl);
    valid_in = v; OpCode = op; Funct = fn; Shamt = sh;
    RsData = rs; RtData = rt; Imm16 = imm; stall = st; flush = fl;
    if (fl)        mstate = '0;
    else if (st)   mstate = mstate;
    else if (v)    mstate = ref_dec(op, fn, sh, rs, rt, imm);
    else           mstate = '0;
    @(posedge clk);
    expq.push_back(mstate);
    #2;
  endtask

  // Monitor: compare DUT against the oldest queued expectation each cycle
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      check_outs("scb", mon_e);
    end
  end

  initial begin
    int n;
    logic [5:0] rop;
    logic [5:0] rfn;

    reset = 1'b0; valid_in = 1'b0; OpCode = '0; Funct = '0; Shamt = '0;
    RsData = '0; RtData = '0; Imm16 = '0; stall = 1'b0; flush = 1'b0;
    mstate = '0;
    #1;
    lit("reset_state", 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    step(1, 6'h00, 6'h22, 5'd0, 32'd5, 32'd7, 16'h0, 0, 0);
    lit("sub", 1, 4'h1, 32'd5, 32'd7, 0);
    step(1, 6'h0C, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd0, 16'h8001, 0, 0);
    lit("andi", 1, 4'h3, 32'hFFFFFFFF, 32'h00008001, 0);
    step(1, 6'h0A, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd0, 16'h8001, 0, 0);
    lit("slti", 1, 4'h8, 32'hFFFFFFFF, 32'hFFFF8001, 0);
    step(1, 6'h00, 6'h00, 5'd4, 32'h55, 32'h77, 16'h0, 0, 0);
    lit("sll", 1, 4'h9, 32'd4, 32'h77, 0);
    step(1, 6'h00, 6'h07, 5'd0, 32'h00000123, 32'h80000000, 16'h0, 0, 0);
    lit("srav", 1, 4'hB, 32'd3, 32'h80000000, 0);
    step(1, 6'h0F, 6'h00, 5'd0, 32'hDEAD, 32'd0, 16'h1234, 0, 0);
    lit("lui", 1, 4'h9, 32'd16, 32'h1234, 0);
    step(1, 6'h07, 6'h00, 5'd0, 32'd9, 32'd5, 16'h0, 0, 0);
    lit("bgtz", 1, 4'hC, 32'd9, 32'd0, 0);
    step(0, 6'h00, 6'h22, 5'd0, 32'd1, 32'd2, 16'h0, 0, 0);
    lit("no_valid", 0, 4'h0, 32'd0, 32'd0, 0);

    step(1, 6'h00, 6'h20, 5'd0, 32'd10, 32'd20, 16'h0, 0, 0);
    lit("add", 1, 4'h0, 32'd10, 32'd20, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'(i), 6'h0D, 6'h27, 5'(i + 1), $urandom, $urandom, 16'($urandom), 1, 0);
      lit("stall_hold", 1, 4'h0, 32'd10, 32'd20, 0);
    end
    step(1, 6'h00, 6'h25, 5'd0, 32'd1, 32'd2, 16'h0, 1, 1);
    lit("stall_flush", 0, 4'h0, 32'd0, 32'd0, 0);

    step(1, 6'h3F, 6'h00, 5'd0, 32'd11, 32'd12, 16'hFFFF, 0, 0);
    lit("illegal", 1, 4'h0, 32'd0, 32'd0, 1);
    step(1, 6'h00, 6'h21, 5'd0, 32'd3, 32'd4, 16'h0, 0, 0);
    lit("after_illegal", 1, 4'h0, 32'd3, 32'd4, 0);

    // Reset asserted between edges while a stalled instruction is held
    step(1, 6'h00, 6'h24, 5'd0, 32'hF0, 32'h3C, 16'h0, 0, 0);
    step(1, 6'h00, 6'h26, 5'd0, 32'h1, 32'h1, 16'h0, 1, 0);
    @(negedge clk);
    #1;
    lit("pre_reset", 1, 4'h3, 32'hF0, 32'h3C, 0);
    reset = 1'b0;
    #1;
    lit("async_reset", 0, 4'h0, 32'd0, 32'd0, 0);
    @(posedge clk);
    #2;
    lit("in_reset", 0, 4'h0, 32'd0, 32'd0, 0);
    reset = 1'b1;
    mstate = '0;
    step(1, 6'h00, 6'h25, 5'd0, 32'h0F, 32'hF0, 16'h0, 0, 0);
    lit("post_reset", 1, 4'h4, 32'h0F, 32'hF0, 0);

    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 4) == 0) ? 6'($urandom) :
            (($urandom_range(0, 2) == 0) ? 6'h00 : legal_ops[$urandom_range(0, 13)]);
      rfn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 17)];
      step(1'($urandom_range(0, 5) != 0), rop, rfn, 5'($urandom), $urandom, $urandom,
           16'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end

    n = 0;
    while (expq.size() > 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state rising-edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port valid_in, input, 1, decode-stage instruction valid.
REQ-004 SHALL have port OpCode, input, 6, instruction bits [31:26].
REQ-005 SHALL have port Funct, input, 6, instruction bits [5:0].
REQ-006 SHALL have port Shamt, input, 5, instruction bits [10:6].
REQ-007 SHALL have ports RsData/RtData, input, 32 each, register-file read values.
REQ-008 SHALL have port Imm16, input, 16, instruction bits [15:0].
REQ-009 SHALL have ports stall and flush, input, 1 each, hazard-unit controls.
REQ-010 SHALL have ports valid_out (1), ALUOp (4), In1 (32), In2 (32), illegal (1), all outputs, registered execute-stage ALU controls.

Function
REQ-011 SHALL register decoded ALUOp/In1/In2/illegal/valid_out on each rising clk edge; latency exactly 1 cycle.
REQ-012 SHALL use ALUOp codes Add=0, Sub=1, And=3, Or=4, Xor=5, Nor=6, Ult=7, Slt=8, Sll=9, Srl=A, Sra=B, Gtz=C; codes 2, D-F never emitted.
REQ-013 SHALL decode OpCode 0x00 by Funct: 20/21 Add, 22/23 Sub, 24 And, 25 Or, 26 Xor, 27 Nor, 2A Slt, 2B Ult, 00 Sll, 02 Srl, 03 Sra, 04 Sll, 06 Srl, 07 Sra, 08/09 (jr/jalr) Add.
REQ-014 SHALL, for Funct 00/02/03, drive In1={27'b0,Shamt}, In2=RtData; for 04/06/07, In1={27'b0,RsData[4:0]}, In2=RtData; other R-type In1=RsData, In2=RtData.
REQ-015 SHALL decode I-type: 08/09 Add, 0A Slt, 0B Ult (sign-extended Imm16); 0C And, 0D Or, 0E Xor (zero-extended Imm16); 23/2B Add (sign-extended); In1=RsData.
REQ-016 SHALL decode 0F (lui) as Sll with In1=32'd16, In2={16'b0,Imm16}.
REQ-017 SHALL decode 04/05 as Sub (In1=RsData, In2=RtData) and 07 as Gtz (In1=RsData, In2=0).
REQ-018 SHALL, for any unlisted OpCode/Funct with valid_in=1, register ALUOp=Add, In1=In2=0, illegal=1, valid_out=1.
REQ-019 SHALL register illegal=0 whenever valid_in=0 or decode is listed.
REQ-020 SHALL hold all registered outputs unchanged on a cycle with stall=1 and flush=0.
REQ-021 SHALL, on flush=1 (regardless of stall), register bubble: valid_out=0, ALUOp=Add, In1=In2=0, illegal=0.
REQ-022 SHALL, when valid_in=0 and no stall/flush, register the bubble values of REQ-021.
REQ-023 SHALL keep outputs a pure function of registered state (no combinational input-to-output path).

Reset
REQ-024 SHALL, while reset=0, asynchronously force valid_out=0, ALUOp=Add, In1=0, In2=0, illegal=0.
REQ-025 SHALL, on reset assertion mid-stall, discard held instruction; first edge after release samples current inputs normally.

Structure
REQ-026 SHALL place ALUOp code constants and OpCode/Funct constants in shared package alu_defs_pkg, also used by the ALU.
REQ-027 SHALL implement decode as combinational sub-module alu_op_decode (OpCode, Funct, Shamt, RsData, RtData, Imm16 -> ALUOp, In1, In2, illegal), with the stage register in alu_ctrl_stage.

Verification
REQ-028 SHALL cover: OpCode=00, Funct=22, RsData=5, RtData=7, valid_in=1 -> next cycle ALUOp=1, In1=5, In2=7, valid_out=1.
REQ-029 SHALL cover: OpCode=0C, Imm16=0x8001, RsData=0xFFFFFFFF -> In2=0x00008001, ALUOp=3; OpCode=0A same Imm16 -> In2=0xFFFF8001, ALUOp=8.
REQ-030 SHALL cover: Funct=00 Shamt=4 -> In1=4, ALUOp=9; Funct=07 RsData=0x00000123 -> In1=3, ALUOp=B; OpCode=0F Imm16=0x1234 -> In1=16, In2=0x1234, ALUOp=9.
REQ-031 SHALL cover: stall=1 for 3 cycles with changing inputs -> outputs frozen; stall=1 and flush=1 same cycle -> bubble (valid_out=0).
REQ-032 SHALL cover: OpCode=3F valid_in=1 -> illegal=1, ALUOp=0, In1=In2=0; next valid add -> illegal=0.
REQ-033 SHALL cover: reset=0 asserted between edges while valid_out=1 -> outputs zero immediately, before next clk edge.
